breakout_block_hit: RTL and testbench

- Write side of the block-visibility vector: owns and updates the 56-bit visibility state that the block renderer reads each pixel.
- On each check request, takes a ball probe point and resolves it to a block cell with an iterative-subtraction divider.
- On a hit, clears that block's visible bit, emits hit/bounce info and updates score and blocks-remaining.
- Sits between the ball/physics logic (issues one check per ball move) and the renderer (consumes visible_out).

---
 rtl/breakout_pkg.sv | 61 ++++++
 rtl/breakout_grid_locate.sv | 87 ++++++++
 rtl/breakout_block_hit.sv | 156 +++++++++++++++
 tb/tb_breakout_block_hit.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/breakout_pkg.sv
// Shared geometry, scoring and state types for the breakout block field.
// Used by the hit checker and the block renderer.
package breakout_pkg;

  localparam int BLOCK_W = 40;
  localparam int BLOCK_H = 20;
  localparam int NUM_X = 14;
  localparam int NUM_Y = 4;
  localparam int SPACING = 5;
  localparam int START_X = 152;
  localparam int START_Y = 150;

  localparam int PITCH_X = BLOCK_W + SPACING;
  localparam int PITCH_Y = BLOCK_H + SPACING;
  localparam int END_X = START_X + NUM_X * PITCH_X - SPACING;
  localparam int END_Y = START_Y + NUM_Y * PITCH_Y - SPACING;
  localparam int NUM_BLOCKS = NUM_X * NUM_Y;

  // 10-bit forms for comparing against pixel coordinates
  localparam logic [9:0] START_X10 = 10'(START_X);
  localparam logic [9:0] START_Y10 = 10'(START_Y);
  localparam logic [9:0] END_X10 = 10'(END_X);
  localparam logic [9:0] END_Y10 = 10'(END_Y);
  localparam logic [9:0] PITCH_X10 = 10'(PITCH_X);
  localparam logic [9:0] PITCH_Y10 = 10'(PITCH_Y);
  localparam logic [9:0] BLOCK_W10 = 10'(BLOCK_W);
  localparam logic [9:0] BLOCK_H10 = 10'(BLOCK_H);

  // Row colours (12-bit RGB) shared with the renderer
  localparam logic [11:0] COLOR_ROW0 = 12'hF00;
  localparam logic [11:0] COLOR_ROW1 = 12'hF80;
  localparam logic [11:0] COLOR_ROW2 = 12'h0F0;
  localparam logic [11:0] COLOR_ROW3 = 12'hFF0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DIV_X,
    S_DIV_Y,
    S_RESOLVE,
    S_DONE
  } hit_state_e;

  typedef enum logic [1:0] {
    L_IDLE,
    L_X,
    L_Y
  } loc_phase_e;

  // Points awarded per row; top row is worth most
  function automatic logic [3:0] row_points(input logic [1:0] row);
    logic [3:0] p;
    unique case (row)
      2'd0: p = 4'd7;
      2'd1: p = 4'd5;
      2'd2: p = 4'd3;
      default: p = 4'd1;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/breakout_grid_locate.sv
// Iterative-subtraction locator: turns a grid-relative offset into
// column/row indices plus the remainder inside the cell.
module breakout_grid_locate
  import breakout_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       start,
  input  logic [9:0] dx_in,
  input  logic [9:0] dy_in,
  output logic [3:0] col,
  output logic [1:0] row,
  output logic [9:0] rem_x,
  output logic [9:0] rem_y,
  output logic       x_done,
  output logic       done
);

  loc_phase_e phase_q, phase_d;
  logic [3:0] col_q, col_d;
  logic [1:0] row_q, row_d;
  logic [9:0] rem_x_q, rem_x_d;
  logic [9:0] rem_y_q, rem_y_d;

  // One subtraction of the pitch per cycle, x first then y
  always_comb begin
    phase_d = phase_q;
    col_d = col_q;
    row_d = row_q;
    rem_x_d = rem_x_q;
    rem_y_d = rem_y_q;
    if (start) begin
      phase_d = L_X;
      col_d = '0;
      row_d = '0;
      rem_x_d = dx_in;
      rem_y_d = dy_in;
    end else begin
      unique case (phase_q)
        L_X: begin
          if (rem_x_q >= PITCH_X10) begin
            rem_x_d = rem_x_q - PITCH_X10;
            col_d = col_q + 4'd1;
          end else begin
            phase_d = L_Y;
          end
        end
        L_Y: begin
          if (rem_y_q >= PITCH_Y10) begin
            rem_y_d = rem_y_q - PITCH_Y10;
            row_d = row_q + 2'd1;
          end else begin
            phase_d = L_IDLE;
          end
        end
        default: phase_d = L_IDLE;
      endcase
    end
    if (clear) phase_d = L_IDLE;
  end

  // Locator state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= L_IDLE;
      col_q <= '0;
      row_q <= '0;
      rem_x_q <= '0;
      rem_y_q <= '0;
    end else begin
      phase_q <= phase_d;
      col_q <= col_d;
      row_q <= row_d;
      rem_x_q <= rem_x_d;
      rem_y_q <= rem_y_d;
    end
  end

  assign col = col_q;
  assign row = row_q;
  assign rem_x = rem_x_q;
  assign rem_y = rem_y_q;
  assign x_done = (phase_q == L_X) && (rem_x_q < PITCH_X10);
  assign done = (phase_q == L_Y) && (rem_y_q < PITCH_Y10);

endmodule

// File: rtl/breakout_block_hit.sv
// Block hit checker: owns the visibility vector, score and block count,
// resolving each ball probe to a cell and clearing struck blocks.
module breakout_block_hit
  import breakout_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        check_req,
  input  logic [9:0]  ball_x,
  input  logic [9:0]  ball_y,
  input  logic        level_reload,
  output logic        check_busy,
  output logic        check_done,
  output logic        hit,
  output logic [5:0]  hit_idx,
  output logic [55:0] visible_out,
  output logic [15:0] score,
  output logic [5:0]  blocks_left,
  output logic        all_cleared
);

  hit_state_e state_q, state_d;
  logic [55:0] visible_q, visible_d;
  logic [15:0] score_q, score_d;
  logic [5:0] blocks_q, blocks_d;
  logic [5:0] hit_idx_q, hit_idx_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic hit_q, hit_d;
  logic pend_q, pend_d;
  logic clr_q, clr_d;

  logic accept, in_grid, loc_start;
  logic loc_x_done, loc_done;
  logic [3:0] loc_col;
  logic [1:0] loc_row;
  logic [9:0] rem_x, rem_y;
  logic [5:0] idx;
  logic strike;
  logic [16:0] score_sum;

  assign in_grid = (ball_x >= START_X10) && (ball_x < END_X10)
                && (ball_y >= START_Y10) && (ball_y < END_Y10);
  assign accept = (state_q == S_IDLE) && !busy_q
               && check_req && !level_reload;
  assign loc_start = accept && in_grid;

  breakout_grid_locate u_locate (
    .clk    (clk),
    .rst    (rst),
    .clear  (level_reload),
    .start  (loc_start),
    .dx_in  (ball_x - START_X10),
    .dy_in  (ball_y - START_Y10),
    .col    (loc_col),
    .row    (loc_row),
    .rem_x  (rem_x),
    .rem_y  (rem_y),
    .x_done (loc_x_done),
    .done   (loc_done)
  );

  assign idx = ({4'd0, loc_row} * 6'(NUM_X)) + {2'd0, loc_col};
  assign strike = (rem_x < BLOCK_W10) && (rem_y < BLOCK_H10)
               && visible_q[idx];
  assign score_sum = {1'b0, score_q} + 17'(row_points(loc_row));

  // Check sequencing, hit resolution and reload handling
  always_comb begin
    state_d = state_q;
    visible_d = visible_q;
    score_d = score_q;
    blocks_d = blocks_q;
    hit_idx_d = hit_idx_q;
    busy_d = busy_q;
    done_d = 1'b0;
    hit_d = 1'b0;
    pend_d = pend_q;
    clr_d = (blocks_q == 6'd0);
    unique case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (accept) begin
          busy_d = 1'b1;
          pend_d = 1'b0;
          state_d = in_grid ? S_DIV_X : S_DONE;
        end
      end
      S_DIV_X: if (loc_x_done) state_d = S_DIV_Y;
      S_DIV_Y: if (loc_done) state_d = S_RESOLVE;
      S_RESOLVE: begin
        if (strike) begin
          visible_d[idx] = 1'b0;
          blocks_d = blocks_q - 6'd1;
          score_d = score_sum[16] ? 16'hFFFF : score_sum[15:0];
          hit_idx_d = idx;
          pend_d = 1'b1;
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        done_d = 1'b1;
        hit_d = pend_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (level_reload) begin
      state_d = S_IDLE;
      visible_d = '1;
      blocks_d = 6'(NUM_BLOCKS);
      clr_d = 1'b0;
      busy_d = 1'b0;
      done_d = 1'b0;
      hit_d = 1'b0;
      pend_d = 1'b0;
    end
  end

  // Registered state and outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      visible_q <= '1;
      score_q <= '0;
      blocks_q <= 6'(NUM_BLOCKS);
      hit_idx_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      hit_q <= 1'b0;
      pend_q <= 1'b0;
      clr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      visible_q <= visible_d;
      score_q <= score_d;
      blocks_q <= blocks_d;
      hit_idx_q <= hit_idx_d;
      busy_q <= busy_d;
      done_q <= done_d;
      hit_q <= hit_d;
      pend_q <= pend_d;
      clr_q <= clr_d;
    end
  end

  assign check_busy = busy_q;
  assign check_done = done_q;
  assign hit = hit_q;
  assign hit_idx = hit_idx_q;
  assign visible_out = visible_q;
  assign score = score_q;
  assign blocks_left = blocks_q;
  assign all_cleared = clr_q;

endmodule

// File: tb/tb_breakout_block_hit.sv
// Self-checking bench for breakout_block_hit: directed table,
// random probes against a geometric model, and abort corner cases.
module tb_breakout_block_hit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic check_req = 1'b0;
  logic [9:0] ball_x = '0;
  logic [9:0] ball_y = '0;
  logic level_reload = 1'b0;
  logic check_busy, check_done, hit;
  logic [5:0] hit_idx;
  logic [55:0] visible_out;
  logic [15:0] score;
  logic [5:0] blocks_left;
  logic all_cleared;

  int n_cmp = 0;
  int n_bad = 0;

  // model state
  bit m_vis [56];
  int m_score;
  int m_blocks;
  int pts [4] = '{7, 5, 3, 1};

  always #5 clk = ~clk;

  breakout_block_hit dut (
    .clk         (clk),
    .rst         (rst),
    .check_req   (check_req),
    .ball_x      (ball_x),
    .ball_y      (ball_y),
    .level_reload(level_reload),
    .check_busy  (check_busy),
    .check_done  (check_done),
    .hit         (hit),
    .hit_idx     (hit_idx),
    .visible_out (visible_out),
    .score       (score),
    .blocks_left (blocks_left),
    .all_cleared (all_cleared)
  );

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [55:0] m_vec();
    logic [55:0] v;
    for (int i = 0; i < 56; i++) v[i] = m_vis[i];
    return v;
  endfunction

  task automatic m_restore();
    for (int i = 0; i < 56; i++) m_vis[i] = 1'b1;
    m_blocks = 56;
  endtask

  // Geometric reference: plain division/modulo on pixel offsets
  task automatic m_probe(input int x, input int y, output bit mh,
                         output int midx, output int mlat);
    int dx, dy, c, r;
    mh = 0;
    midx = 0;
    if (x < 152 || x >= 777 || y < 150 || y >= 245) begin
      mlat = 1;
    end else begin
      dx = x - 152;
      dy = y - 150;
      c = dx / 45;
      r = dy / 25;
      mlat = c + r + 4;
      midx = r * 14 + c;
      mh = (dx % 45 < 40) && (dy % 25 < 20) && m_vis[midx];
      if (mh) begin
        m_vis[midx] = 1'b0;
        m_blocks--;
        m_score = m_score + pts[r];
        if (m_score > 65535) m_score = 65535;
      end
    end
  endtask

  // Issue one request and wait for its done pulse; lat=0 on timeout
  task automatic do_check(input int x, input int y, input int poke,
                          output bit gh, output int gidx,
                          output int glat);
    int n;
    n = 0;
    @(negedge clk);
    while (check_busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    ball_x = 10'(x);
    ball_y = 10'(y);
    check_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_req = 1'b0;
    gh = 0;
    gidx = 0;
    glat = 0;
    for (int k = 1; k <= 45; k++) begin
      @(posedge clk);
      #1;
      check_req = 1'b0;
      if (check_done) begin
        gh = hit;
        gidx = int'(hit_idx);
        glat = k;
        break;
      end
      if (k == poke) begin
        ball_x = 10'd152;
        ball_y = 10'd175;
        check_req = 1'b1;
      end
    end
    if (glat == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout: no check_done for (%0d,%0d)", x, y);
    end
  endtask

  task automatic run_model(input int x, input int y);
    bit gh, mh;
    int gidx, glat, midx, mlat;
    m_probe(x, y, mh, midx, mlat);
    do_check(x, y, 0, gh, gidx, glat);
    chk("rnd_hit", 64'(gh), 64'(mh));
    if (mh) chk("rnd_idx", 64'(gidx), 64'(midx));
    chk("rnd_lat", 64'(glat), 64'(mlat));
    chk("rnd_score", 64'(score), 64'(m_score));
    chk("rnd_blocks", 64'(blocks_left), 64'(m_blocks));
    chk("rnd_vis", 64'(visible_out), 64'(m_vec()));
  endtask

  typedef struct {
    int x;
    int y;
    bit e_hit;
    int e_idx;
    int e_lat;
    int e_score;
  } vec_t;

  vec_t tbl [10];

  initial begin
    bit gh, mh;
    int gidx, glat, midx, mlat, dn;

    tbl[0] = '{152, 150, 1, 0, 4, 7};
    tbl[1] = '{152, 150, 0, 0, 4, 7};
    tbl[2] = '{192, 150, 0, 0, 4, 7};
    tbl[3] = '{100, 100, 0, 0, 1, 7};
    tbl[4] = '{776, 244, 1, 55, 20, 8};
    tbl[5] = '{777, 200, 0, 0, 1, 8};
    tbl[6] = '{151, 150, 0, 0, 1, 8};
    tbl[7] = '{152, 245, 0, 0, 1, 8};
    tbl[8] = '{152, 244, 1, 42, 7, 9};
    tbl[9] = '{152, 170, 0, 0, 4, 9};

    m_restore();
    m_score = 0;

    // reset and idle
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    dn = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (check_done) dn++;
    end
    chk("rst_vis", 64'(visible_out), 64'h00FF_FFFF_FFFF_FFFF);
    chk("rst_score", 64'(score), 64'd0);
    chk("rst_blocks", 64'(blocks_left), 64'd56);
    chk("rst_clr", 64'(all_cleared), 64'd0);
    chk("rst_busy", 64'(check_busy), 64'd0);
    chk("rst_nodone", 64'(dn), 64'd0);

    // directed table
    foreach (tbl[i]) begin
      m_probe(tbl[i].x, tbl[i].y, mh, midx, mlat);
      do_check(tbl[i].x, tbl[i].y, 0, gh, gidx, glat);
      chk($sformatf("tbl%0d_hit", i), 64'(gh), 64'(tbl[i].e_hit));
      if (tbl[i].e_hit)
        chk($sformatf("tbl%0d_idx", i), 64'(gidx), 64'(tbl[i].e_idx));
      chk($sformatf("tbl%0d_lat", i), 64'(glat), 64'(tbl[i].e_lat));
      chk($sformatf("tbl%0d_score", i), 64'(score),
          64'(tbl[i].e_score));
      chk($sformatf("tbl%0d_vis", i), 64'(visible_out), 64'(m_vec()));
    end

    // request during busy is dropped: col12 row3 with a poke
    m_probe(731, 244, mh, midx, mlat);
    do_check(731, 244, 5, gh, gidx, glat);
    chk("busy_hit", 64'(gh), 64'd1);
    chk("busy_idx", 64'(gidx), 64'd54);
    chk("busy_lat", 64'(glat), 64'd19);
    dn = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk);
      #1;
      if (check_done) dn++;
    end
    chk("busy_onedone", 64'(dn), 64'd0);
    chk("busy_vis", 64'(visible_out), 64'(m_vec()));

    // random probes
    for (int i = 0; i < 60; i++)
      run_model(int'($urandom_range(790, 140)),
                int'($urandom_range(250, 140)));

    // clear every cell
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 14; c++)
        run_model(152 + c * 45 + 10, 150 + r * 25 + 5);
    chk("clr_score", 64'(score), 64'd224);
    chk("clr_blocks", 64'(blocks_left), 64'd0);
    @(posedge clk);
    #1;
    chk("clr_flag", 64'(all_cleared), 64'd1);
    run_model(300, 200);
    chk("clr_still", 64'(all_cleared), 64'd1);

    // level reload keeps score
    @(negedge clk);
    level_reload = 1'b1;
    @(posedge clk);
    #1;
    level_reload = 1'b0;
    m_restore();
    chk("rl_vis", 64'(visible_out), 64'h00FF_FFFF_FFFF_FFFF);
    chk("rl_blocks", 64'(blocks_left), 64'd56);
    chk("rl_score", 64'(score), 64'd224);
    chk("rl_clr", 64'(all_cleared), 64'd0);
    run_model(152, 150);

    // reload while dividing a col-10 probe
    @(negedge clk);
    ball_x = 10'd602;
    ball_y = 10'd150;
    check_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    level_reload = 1'b1;
    @(posedge clk);
    #1;
    m_restore();
    chk("ab_busy", 64'(check_busy), 64'd0);
    chk("ab_vis", 64'(visible_out), 64'h00FF_FFFF_FFFF_FFFF);
    chk("ab_score", 64'(score), 64'(m_score));
    @(negedge clk);
    level_reload = 1'b0;
    dn = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (check_done) dn++;
    end
    chk("ab_nodone", 64'(dn), 64'd0);
    chk("ab_blocks", 64'(blocks_left), 64'd56);

    // async reset during the row division
    run_model(152, 150);
    @(negedge clk);
    ball_x = 10'd197;
    ball_y = 10'd225;
    check_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_req = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("ar_score", 64'(score), 64'd0);
    chk("ar_vis", 64'(visible_out), 64'h00FF_FFFF_FFFF_FFFF);
    chk("ar_blocks", 64'(blocks_left), 64'd56);
    chk("ar_busy", 64'(check_busy), 64'd0);
    chk("ar_done", 64'(check_done), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    m_restore();
    m_score = 0;
    dn = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (check_done) dn++;
    end
    chk("ar_nodone", 64'(dn), 64'd0);
    run_model(197, 225);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
